// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: shared widths, types and enums for the framebuffer arbiter.
package vga_fb_pkg;
    localparam int AXIL_DATA_W = 32;
    localparam int FB_ADDR_W   = 16;
    localparam int FB_DATA_W   = AXIL_DATA_W;
    typedef logic [FB_ADDR_W-1:0] fb_addr_t;
    typedef logic [FB_DATA_W-1:0] fb_data_t;
    typedef enum logic [1:0] {SLOT_IDLE, SLOT_PEND_RD, SLOT_PEND_WR} slot_state_e;
    typedef enum logic {OWN_PX, OWN_HOST} owner_e;
endpackage

// File: rtl/vga_fb_host_slot.sv
// vga_fb_host_slot: one-deep pending host access with starvation wait counter.
module vga_fb_host_slot
    import vga_fb_pkg::*;
#(
    parameter int ADDR_W        = FB_ADDR_W,
    parameter int DATA_W        = FB_DATA_W,
    parameter int MAX_HOST_WAIT = 4
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              rd_i,
    input  logic              wr_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              grant_i,
    output logic              pending_o,
    output logic              is_write_o,
    output logic              host_force_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o
);
    localparam logic [3:0] MAX_W = 4'(MAX_HOST_WAIT);
    slot_state_e       state_q, state_d;
    logic [3:0]        wait_q, wait_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d, accept;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q <= SLOT_IDLE;
            wait_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    // A pending access that is not granted has lost to pixel traffic.
    always_comb begin
        accept  = (state_q == SLOT_IDLE) && (rd_i ^ wr_i);
        state_d = grant_i ? SLOT_IDLE : accept ? (wr_i ? SLOT_PEND_WR : SLOT_PEND_RD) : state_q;
        wait_d  = grant_i ? '0 : (state_q != SLOT_IDLE && wait_q != MAX_W) ? wait_q + 4'd1 : wait_q;
        addr_d  = accept ? addr_i : addr_q;
        wdata_d = (accept && wr_i) ? wdata_i : wdata_q;
        err_d   = (rd_i && wr_i) || (state_q != SLOT_IDLE && (rd_i || wr_i));
    end

    always_comb begin
        pending_o    = state_q != SLOT_IDLE;
        is_write_o   = state_q == SLOT_PEND_WR;
        host_force_o = (state_q != SLOT_IDLE) && (wait_q == MAX_W);
        err_o        = err_q;
        addr_o       = addr_q;
        wdata_o      = wdata_q;
    end
endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer RAM between pixel fetch and host port.
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int ADDR_W        = FB_ADDR_W,
    parameter int DATA_W        = FB_DATA_W,
    parameter int MAX_HOST_WAIT = 4
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              px_req_i,
    input  logic [ADDR_W-1:0] px_addr_i,
    output logic              px_gnt_o,
    output logic              px_rvalid_o,
    output logic [DATA_W-1:0] px_rdata_o,
    input  logic              host_rd_i,
    input  logic              host_wr_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_wdata_i,
    output logic              host_busy_o,
    output logic              host_rvalid_o,
    output logic [DATA_W-1:0] host_rdata_o,
    output logic              host_wdone_o,
    output logic              host_err_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);
    logic              pending, is_write, host_force, host_gnt, px_gnt, rd_q, wdone_q, slot_err;
    logic [ADDR_W-1:0] slot_addr, addr_last_q;
    logic [DATA_W-1:0] slot_wdata, wdata_last_q, host_rdata_q;
    owner_e            tag_q;

    vga_fb_host_slot #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOST_WAIT(MAX_HOST_WAIT)
    ) u_slot (
        .clk(clk), .arst_n(arst_n), .rd_i(host_rd_i), .wr_i(host_wr_i),
        .addr_i(host_addr_i), .wdata_i(host_wdata_i), .grant_i(host_gnt),
        .pending_o(pending), .is_write_o(is_write), .host_force_o(host_force),
        .err_o(slot_err), .addr_o(slot_addr), .wdata_o(slot_wdata)
    );

    // Grants are masked while reset is asserted so nothing reaches the RAM.
    always_comb begin
        host_gnt      = arst_n && (host_force || (pending && !px_req_i));
        px_gnt        = arst_n && px_req_i && !host_force;
        px_gnt_o      = px_gnt;
        mem_en_o      = px_gnt || host_gnt;
        mem_we_o      = host_gnt && is_write;
        mem_addr_o    = px_gnt ? px_addr_i : host_gnt ? slot_addr : addr_last_q;
        mem_wdata_o   = mem_we_o ? slot_wdata : wdata_last_q;
        px_rvalid_o   = rd_q && (tag_q == OWN_PX);
        host_rvalid_o = rd_q && (tag_q == OWN_HOST);
        px_rdata_o    = arst_n ? mem_rdata_i : '0;
        host_rdata_o  = host_rvalid_o ? mem_rdata_i : host_rdata_q;
        host_wdone_o  = wdone_q;
        host_err_o    = slot_err;
        host_busy_o   = pending;
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            rd_q         <= 1'b0;
            tag_q        <= OWN_PX;
            wdone_q      <= 1'b0;
            addr_last_q  <= '0;
            wdata_last_q <= '0;
            host_rdata_q <= '0;
        end else begin
            rd_q         <= px_gnt || (host_gnt && !is_write);
            tag_q        <= px_gnt ? OWN_PX : OWN_HOST;
            wdone_q      <= mem_we_o;
            addr_last_q  <= mem_addr_o;
            wdata_last_q <= mem_wdata_o;
            if (host_rvalid_o) host_rdata_q <= mem_rdata_i;
        end
    end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed + randomized scoreboard bench for vga_fb_arbiter.
module tb_vga_fb_arbiter;
    import vga_fb_pkg::*;
    localparam int MAXW = 4;
    typedef struct { logic [31:0] d; int t0; int lat; } hexp_t;

    logic clk = 1'b0, arst_n = 1'b0;
    logic px_req_i = 1'b0, host_rd_i = 1'b0, host_wr_i = 1'b0;
    logic [15:0] px_addr_i = '0, host_addr_i = '0;
    logic [31:0] host_wdata_i = '0;
    logic px_gnt_o, px_rvalid_o, host_busy_o, host_rvalid_o, host_wdone_o, host_err_o, mem_en_o, mem_we_o;
    logic [31:0] px_rdata_o, host_rdata_o, mem_wdata_o, mem_rdata_i, ram_q;
    logic [15:0] mem_addr_o;
    fb_data_t ram [0:65535];
    fb_data_t ref_mem [0:65535];
    logic [31:0] px_q [$];
    hexp_t hq [$], wq [$];
    int exp_err = 0, errors = 0, checks = 0, cyc = 0;
    logic px_gnt_s = 1'b0, flag;
    logic [5:0] gp, ge;

    vga_fb_arbiter #(.ADDR_W(16), .DATA_W(32), .MAX_HOST_WAIT(MAXW)) dut (
        .clk(clk), .arst_n(arst_n), .px_req_i(px_req_i), .px_addr_i(px_addr_i),
        .px_gnt_o(px_gnt_o), .px_rvalid_o(px_rvalid_o), .px_rdata_o(px_rdata_o),
        .host_rd_i(host_rd_i), .host_wr_i(host_wr_i), .host_addr_i(host_addr_i),
        .host_wdata_i(host_wdata_i), .host_busy_o(host_busy_o), .host_rvalid_o(host_rvalid_o),
        .host_rdata_o(host_rdata_o), .host_wdone_o(host_wdone_o), .host_err_o(host_err_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign mem_rdata_i = ram_q;

    // Behavioural single-port RAM with one-cycle read latency.
    always @(posedge clk)
        if (mem_en_o) begin
            if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
            else ram_q <= ram[mem_addr_o];
        end

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        host_rd_i = 1'b0;
        host_wr_i = 1'b0;
    endtask

    function automatic logic [31:0] pat(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic outs_or();
        return |{px_gnt_o, px_rvalid_o, px_rdata_o, host_busy_o, host_rvalid_o, host_rdata_o,
                 host_wdone_o, host_err_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o};
    endfunction

    // Monitor: pops expectations whenever the DUT presents a response.
    always @(negedge clk) begin
        hexp_t h;
        logic [31:0] e;
        int lat;
        px_gnt_s = px_gnt_o;
        if (arst_n) begin
            chk(!(mem_we_o && !mem_en_o), "we_without_en", {63'd0, mem_we_o}, 64'd0);
            if (px_rvalid_o && host_rvalid_o) chk(1'b0, "both_rvalid", 64'd1, 64'd0);
            if (px_rvalid_o) begin
                if (px_q.size() == 0) chk(1'b0, "px_rvalid_unexpected", 64'(px_rdata_o), 64'd0);
                else begin
                    e = px_q.pop_front();
                    chk(px_rdata_o == e, "px_rdata", 64'(px_rdata_o), 64'(e));
                end
            end
            if (host_rvalid_o) begin
                if (hq.size() == 0) chk(1'b0, "host_rvalid_unexpected", 64'(host_rdata_o), 64'd0);
                else begin
                    h = hq.pop_front();
                    lat = cyc - h.t0;
                    chk(host_rdata_o == h.d, "host_rdata", 64'(host_rdata_o), 64'(h.d));
                    chk(h.lat != 0 ? lat == h.lat : (lat >= 2 && lat <= MAXW + 2), "host_rd_latency",
                        64'(lat), 64'(h.lat != 0 ? h.lat : MAXW + 2));
                end
            end
            if (host_wdone_o) begin
                if (wq.size() == 0) chk(1'b0, "host_wdone_unexpected", 64'd1, 64'd0);
                else begin
                    h = wq.pop_front();
                    lat = cyc - h.t0;
                    chk(h.lat != 0 ? lat == h.lat : (lat >= 2 && lat <= MAXW + 2), "host_wr_latency",
                        64'(lat), 64'(h.lat != 0 ? h.lat : MAXW + 2));
                end
            end
            if (host_err_o) begin
                if (exp_err == 0) chk(1'b0, "host_err_unexpected", 64'd1, 64'd0);
                else exp_err--;
            end
            if (px_gnt_o) px_q.push_back(ref_mem[px_addr_i]);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram[i] = pat(i);
            ref_mem[i] = pat(i);
        end
        ram[1] = 32'h11; ref_mem[1] = 32'h11;
        ram[2] = 32'h22; ref_mem[2] = 32'h22;
        ram_q = '0;
        repeat (3) step();
        @(negedge clk);
        chk(!outs_or(), "reset_outputs", {63'd0, outs_or()}, 64'd0);
        step();
        arst_n = 1'b1;

        // Host write then read-back
        step();
        host_wr_i = 1'b1; host_addr_i = 16'h0010; host_wdata_i = 32'hDEADBEEF;
        ref_mem[16'h0010] = 32'hDEADBEEF;
        wq.push_back('{32'hDEADBEEF, cyc, 2});
        step(); clr();
        @(negedge clk);
        chk(mem_en_o && mem_we_o && mem_addr_o == 16'h0010 && mem_wdata_o == 32'hDEADBEEF,
            "t1_write_issue", {mem_en_o, mem_we_o, 14'd0, mem_addr_o, mem_wdata_o}, {2'b11, 14'd0, 16'h0010, 32'hDEADBEEF});
        step();
        @(negedge clk);
        chk(host_wdone_o, "t1_wdone", {63'd0, host_wdone_o}, 64'd1);
        step();
        host_rd_i = 1'b1; host_addr_i = 16'h0010;
        hq.push_back('{32'hDEADBEEF, cyc, 2});
        step(); clr();
        step();
        @(negedge clk);
        chk(host_rvalid_o && host_rdata_o == 32'hDEADBEEF, "t1_readback", {31'd0, host_rvalid_o, host_rdata_o}, {31'd0, 1'b1, 32'hDEADBEEF});

        // Pixel saturation with a pending host read
        step();
        px_req_i = 1'b1; px_addr_i = 16'h8000;
        host_rd_i = 1'b1; host_addr_i = 16'h0002;
        hq.push_back('{32'h22, cyc, MAXW + 2});
        step(); clr();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            gp[5-i] = px_gnt_o;
            ge[5-i] = mem_en_o;
            step();
        end
        px_req_i = 1'b0;
        chk(gp == 6'b111101, "t2_px_gnt_pattern", 64'(gp), 64'(6'b111101));
        chk(ge == 6'b111111, "t2_mem_en_pattern", 64'(ge), 64'(6'b111111));

        // Rejects: rd+wr together, then a write while busy
        step();
        host_rd_i = 1'b1; host_wr_i = 1'b1; host_addr_i = 16'h0003;
        exp_err++;
        step(); clr();
        @(negedge clk);
        chk(!mem_en_o && host_err_o, "t3_rdwr_reject", {62'd0, mem_en_o, host_err_o}, 64'd1);
        step();
        px_req_i = 1'b1; px_addr_i = 16'h8001;
        host_wr_i = 1'b1; host_addr_i = 16'h0020; host_wdata_i = 32'hA5A50001;
        ref_mem[16'h0020] = 32'hA5A50001;
        wq.push_back('{32'hA5A50001, cyc, 0});
        step();
        host_wr_i = 1'b1; host_addr_i = 16'h0020; host_wdata_i = 32'h0BAD0BAD;
        exp_err++;
        @(negedge clk);
        chk(host_busy_o, "t3_busy", {63'd0, host_busy_o}, 64'd1);
        step(); clr(); px_req_i = 1'b0;
        @(negedge clk);
        chk(host_err_o, "t3_busy_err", {63'd0, host_err_o}, 64'd1);
        step(); step();
        host_rd_i = 1'b1; host_addr_i = 16'h0020;
        hq.push_back('{32'hA5A50001, cyc, 2});
        step(); clr();
        step();
        @(negedge clk);
        chk(host_rvalid_o && host_rdata_o == 32'hA5A50001, "t3_first_write_kept", 64'(host_rdata_o), 64'(32'hA5A50001));

        // Return steering
        step();
        px_req_i = 1'b1; px_addr_i = 16'h0001;
        host_rd_i = 1'b1; host_addr_i = 16'h0002;
        hq.push_back('{32'h22, cyc, 2});
        step(); clr(); px_req_i = 1'b0;
        @(negedge clk);
        chk(px_rvalid_o && !host_rvalid_o && px_rdata_o == 32'h11, "t4_px_return", {30'd0, px_rvalid_o, host_rvalid_o, px_rdata_o}, {30'd0, 2'b10, 32'h11});
        step();
        @(negedge clk);
        chk(host_rvalid_o && !px_rvalid_o && host_rdata_o == 32'h22, "t4_host_return", {30'd0, host_rvalid_o, px_rvalid_o, host_rdata_o}, {30'd0, 2'b10, 32'h22});

        // Reset with a write pending behind pixel traffic
        step();
        px_req_i = 1'b1; px_addr_i = 16'h8002;
        host_wr_i = 1'b1; host_addr_i = 16'h0030; host_wdata_i = 32'h55AA55AA;
        step(); clr();
        step();
        arst_n = 1'b0; px_req_i = 1'b0;
        step();
        @(negedge clk);
        chk(!outs_or(), "t5_outputs_in_reset", {63'd0, outs_or()}, 64'd0);
        px_q.delete(); hq.delete(); wq.delete(); exp_err = 0;
        step();
        arst_n = 1'b1;
        flag = 1'b0;
        repeat (10) begin
            @(negedge clk);
            flag |= mem_we_o | host_wdone_o | host_rvalid_o | px_rvalid_o;
            step();
        end
        chk(!flag, "t5_quiet_after_reset", {63'd0, flag}, 64'd0);
        chk(ram[16'h0030] == ref_mem[16'h0030], "t5_ram_untouched", 64'(ram[16'h0030]), 64'(ref_mem[16'h0030]));

        // Idle
        flag = 1'b0;
        repeat (20) begin
            @(negedge clk);
            flag |= mem_en_o | px_gnt_o | px_rvalid_o | host_rvalid_o | host_wdone_o | host_err_o | host_busy_o;
            step();
        end
        chk(!flag, "t6_idle_quiet", {63'd0, flag}, 64'd0);
        chk(dut.u_slot.wait_q == 4'd0, "t6_wait_cnt", 64'(dut.u_slot.wait_q), 64'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step(); clr();
            if (!px_req_i || px_gnt_s) begin
                px_req_i = ($urandom_range(0, 2) != 0);
                px_addr_i = 16'h8000 | 16'($urandom_range(0, 255));
            end
            if (hq.size() == 0 && wq.size() == 0 && exp_err == 0 && $urandom_range(0, 3) == 0) begin
                int k;
                logic [15:0] a;
                logic [31:0] d;
                k = $urandom_range(0, 9);
                d = $urandom;
                if (k == 0) begin
                    host_rd_i = 1'b1; host_wr_i = 1'b1; host_addr_i = 16'($urandom_range(0, 511));
                    exp_err++;
                end else if (k < 5) begin
                    a = 16'h0100 | 16'($urandom_range(0, 255));
                    host_wr_i = 1'b1; host_addr_i = a; host_wdata_i = d;
                    ref_mem[a] = d;
                    wq.push_back('{d, cyc, 0});
                end else begin
                    a = 16'($urandom_range(0, 511));
                    host_rd_i = 1'b1; host_addr_i = a;
                    hq.push_back('{ref_mem[a], cyc, 0});
                end
            end
        end
        step(); clr(); px_req_i = 1'b0;
        for (int i = 0; i < 40 && (hq.size() + wq.size() + px_q.size() + exp_err) != 0; i++) step();
        chk((hq.size() + wq.size() + px_q.size() + exp_err) == 0, "drain_outstanding",
            64'(hq.size() + wq.size() + px_q.size() + exp_err), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
